trdb_branch_packer: RTL and testbench

TRDB_BRANCH_PACKER -- requirements
Module: trdb_branch_packer

---
 rtl/trdb_branch_packer.sv | 146 ++++++++++++++
 tb/tb_trdb_branch_packer.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/trdb_branch_packer.sv
// trdb_branch_packer: turns the branch map held by the map stage into a
// branch packet. A packet is produced when the map is full, or when packet
// control requests one and the map is not empty. The map stage is told to
// clear itself (flush_o) in the same cycle the packet fields are captured.
// The packet is held stable until the consumer accepts it. A new trigger can
// be accepted in the cycle of that handshake, so there is no idle gap.
//
// Optional feature: define TRDB_BRANCH_PACKER_STATS_EN to add pkt_count_o.
// This is a saturating 16-bit count of completed packet handshakes.
module trdb_branch_packer #(
    parameter int MAP_LEN = 31
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [MAP_LEN-1:0] map_i,
    input  logic [4:0]         branches_i,
    input  logic               is_full_i,
    input  logic               is_empty_i,
    input  logic               pkt_req_i,
    output logic               flush_o,
    output logic               pkt_valid_o,
    input  logic               pkt_ready_i,
    output logic [4:0]         pkt_branches_o,
    output logic [MAP_LEN-1:0] pkt_map_o,
    output logic [4:0]         pkt_map_len_o,
    output logic               pkt_addr_o
`ifdef TRDB_BRANCH_PACKER_STATS_EN
    ,
    output logic [15:0]        pkt_count_o
`endif
);

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic               trigger;
    logic               handshake;
    logic               accept;
    logic [MAP_LEN-1:0] map_masked;
    logic [4:0]         map_len;
    logic               full_only;

    // Trigger, acceptance, and next-state decode.
    always_comb begin
        // NOTE: every signal gets a default first, so no path can infer a latch.
        state_d   = state_q;
        trigger   = is_full_i | (pkt_req_i & ~is_empty_i);
        handshake = (state_q == HOLD) & pkt_ready_i;
        accept    = 1'b0;

        case (state_q)
            IDLE: begin
                accept = trigger;
            end
            HOLD: begin
                // A pending trigger waits (the map stage keeps its content)
                // until the held packet is taken. It is then accepted in the
                // handshake cycle.
                accept = trigger & pkt_ready_i;
            end
            default: begin
                accept = 1'b0;
            end
        endcase

        if (accept) begin
            state_d = HOLD;
        end else if (handshake) begin
            state_d = IDLE;
        end
    end

    // The flush is suppressed while reset is held, so the map stage is
    // never cleared by a trigger seen during reset.
    assign flush_o = accept & ~rst_i;

    // Packed-map contents: drop the stale bits above the valid branch count,
    // then pick the smallest legal field width that covers them.
    always_comb begin
        map_masked = '0;
        for (int i = 0; i < MAP_LEN; i++) begin
            map_masked[i] = map_i[i] & (branches_i > i[4:0]);
        end

        if (branches_i <= 5'd1) begin
            map_len = 5'd1;
        end else if (branches_i <= 5'd9) begin
            map_len = 5'd9;
        end else if (branches_i <= 5'd17) begin
            map_len = 5'd17;
        end else if (branches_i <= 5'd25) begin
            map_len = 5'd25;
        end else begin
            map_len = 5'd31;
        end

        // A full map with no request is sent as a count-0, address-less
        // packet. Any request (even with a full map) carries the real count
        // and an address.
        full_only = is_full_i & ~pkt_req_i;
    end

    // State register. The valid output is decoded from this registered state.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            // NOTE: sequential state uses non-blocking assignment, so every
            // register samples its pre-edge inputs.
            state_q <= state_d;
        end
    end

    assign pkt_valid_o = (state_q == HOLD);

    // Packet field capture on acceptance. The fields hold otherwise.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pkt_branches_o <= '0;
            pkt_map_o      <= '0;
            pkt_map_len_o  <= 5'd1;
            pkt_addr_o     <= 1'b0;
        end else if (accept) begin
            pkt_branches_o <= full_only ? 5'd0 : branches_i;
            pkt_map_o      <= map_masked;
            pkt_map_len_o  <= map_len;
            pkt_addr_o     <= ~full_only;
        end
    end

`ifdef TRDB_BRANCH_PACKER_STATS_EN
    // Saturating count of packets handed to the consumer.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pkt_count_o <= '0;
        end else if (handshake && (pkt_count_o != 16'hFFFF)) begin
            pkt_count_o <= pkt_count_o + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_trdb_branch_packer.sv
// Directed bench for trdb_branch_packer (default build, stats disabled).
// Inputs are driven 1 time unit after the rising edge. Registered outputs
// are sampled at that point as well. The combinational flush is sampled
// 1 more unit later, once the new inputs have settled.
module tb_trdb_branch_packer;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [30:0] map_i;
    logic [4:0]  branches_i;
    logic        is_full_i;
    logic        is_empty_i;
    logic        pkt_req_i;
    logic        flush_o;
    logic        pkt_valid_o;
    logic        pkt_ready_i;
    logic [4:0]  pkt_branches_o;
    logic [30:0] pkt_map_o;
    logic [4:0]  pkt_map_len_o;
    logic        pkt_addr_o;

    int checks   = 0;
    int failures = 0;

    trdb_branch_packer #(.MAP_LEN(31)) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .map_i          (map_i),
        .branches_i     (branches_i),
        .is_full_i      (is_full_i),
        .is_empty_i     (is_empty_i),
        .pkt_req_i      (pkt_req_i),
        .flush_o        (flush_o),
        .pkt_valid_o    (pkt_valid_o),
        .pkt_ready_i    (pkt_ready_i),
        .pkt_branches_o (pkt_branches_o),
        .pkt_map_o      (pkt_map_o),
        .pkt_map_len_o  (pkt_map_len_o),
        .pkt_addr_o     (pkt_addr_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance to 1 unit after the next rising edge.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive(input logic full, input logic req, input logic empty,
                         input logic [4:0] br, input logic [30:0] map, input logic rdy);
        is_full_i   = full;
        pkt_req_i   = req;
        is_empty_i  = empty;
        branches_i  = br;
        map_i       = map;
        pkt_ready_i = rdy;
    endtask

    task automatic check_pkt(input string tag, input logic [4:0] br, input logic [30:0] map,
                             input logic [4:0] len, input logic addr);
        check({tag, ".valid"},    {31'd0, pkt_valid_o}, 32'd1);
        check({tag, ".branches"}, {27'd0, pkt_branches_o}, {27'd0, br});
        check({tag, ".map"},      {1'b0, pkt_map_o}, {1'b0, map});
        check({tag, ".len"},      {27'd0, pkt_map_len_o}, {27'd0, len});
        check({tag, ".addr"},     {31'd0, pkt_addr_o}, {31'd0, addr});
    endtask

    // Field-width boundary table: branch count -> expected map field width.
    logic [4:0] len_br  [6] = '{5'd1, 5'd9, 5'd10, 5'd17, 5'd25, 5'd26};
    logic [4:0] len_exp [6] = '{5'd1, 5'd9, 5'd17, 5'd17, 5'd25, 5'd31};

    initial begin
        rst_i = 1'b1;
        drive(1'b1, 1'b0, 1'b0, 5'd31, 31'h7FFFFFFF, 1'b1);
        #12;
        check("rst.valid",    {31'd0, pkt_valid_o}, 32'd0);
        check("rst.flush",    {31'd0, flush_o}, 32'd0);
        check("rst.addr",     {31'd0, pkt_addr_o}, 32'd0);
        check("rst.branches", {27'd0, pkt_branches_o}, 32'd0);
        check("rst.map",      {1'b0, pkt_map_o}, 32'd0);
        check("rst.len",      {27'd0, pkt_map_len_o}, 32'd1);

        tick();
        drive(1'b0, 1'b0, 1'b1, 5'd0, 31'd0, 1'b1);
        rst_i = 1'b0;

        // Full map, no request.
        tick();
        drive(1'b1, 1'b0, 1'b0, 5'd31, 31'h2AAAAAAA, 1'b1);
        #1 check("full.flush", {31'd0, flush_o}, 32'd1);
        tick();
        drive(1'b0, 1'b0, 1'b1, 5'd0, 31'd0, 1'b1);
        check_pkt("full", 5'd0, 31'h2AAAAAAA, 5'd31, 1'b0);
        #1 check("full.flush_after", {31'd0, flush_o}, 32'd0);
        tick();
        check("full.valid_drop", {31'd0, pkt_valid_o}, 32'd0);

        // Request with 5 branches: stale upper bits masked off.
        drive(1'b0, 1'b1, 1'b0, 5'd5, 31'h7FFFFFFF, 1'b1);
        #1 check("req5.flush", {31'd0, flush_o}, 32'd1);
        tick();
        drive(1'b0, 1'b0, 1'b1, 5'd0, 31'd0, 1'b1);
        check_pkt("req5", 5'd5, 31'h1F, 5'd9, 1'b1);
        tick();
        check("req5.valid_drop", {31'd0, pkt_valid_o}, 32'd0);

        // Request with an empty map is ignored.
        drive(1'b0, 1'b1, 1'b1, 5'd0, 31'h7FFFFFFF, 1'b1);
        for (int i = 0; i < 10; i++) begin
            #1;
            check("empty.flush", {31'd0, flush_o}, 32'd0);
            check("empty.valid", {31'd0, pkt_valid_o}, 32'd0);
            tick();
        end

        // Back-pressure with a pending trigger, then back-to-back.
        drive(1'b0, 1'b1, 1'b0, 5'd3, 31'h5, 1'b0);
        #1 check("bp.flush_accept", {31'd0, flush_o}, 32'd1);
        for (int i = 0; i < 4; i++) begin
            tick();
            drive(1'b0, 1'b1, 1'b0, 5'd20, 31'h7FFFFFFF, 1'b0);
            check_pkt("bp.hold", 5'd3, 31'h5, 5'd9, 1'b1);
            #1 check("bp.flush_blocked", {31'd0, flush_o}, 32'd0);
        end
        pkt_ready_i = 1'b1;
        #1 check("bp.flush_b2b", {31'd0, flush_o}, 32'd1);
        tick();
        drive(1'b0, 1'b0, 1'b1, 5'd0, 31'd0, 1'b1);
        check_pkt("b2b", 5'd20, 31'hFFFFF, 5'd25, 1'b1);
        tick();
        check("b2b.valid_drop", {31'd0, pkt_valid_o}, 32'd0);

        // Full and request together.
        drive(1'b1, 1'b1, 1'b0, 5'd31, 31'h7FFFFFFF, 1'b1);
        #1 check("fullreq.flush", {31'd0, flush_o}, 32'd1);
        tick();
        drive(1'b0, 1'b0, 1'b1, 5'd0, 31'd0, 1'b1);
        check_pkt("fullreq", 5'd31, 31'h7FFFFFFF, 5'd31, 1'b1);
        tick();

        // Map field width boundaries.
        for (int k = 0; k < 6; k++) begin
            drive(1'b0, 1'b1, 1'b0, len_br[k], 31'h7FFFFFFF, 1'b1);
            tick();
            drive(1'b0, 1'b0, 1'b1, 5'd0, 31'd0, 1'b1);
            check_pkt("len", len_br[k], 31'h7FFFFFFF >> (5'd31 - len_br[k]), len_exp[k], 1'b1);
            tick();
        end

        // Reset while holding a packet discards it immediately.
        drive(1'b0, 1'b1, 1'b0, 5'd7, 31'h55, 1'b0);
        tick();
        drive(1'b0, 1'b0, 1'b1, 5'd0, 31'd0, 1'b0);
        check("rsthold.valid_before", {31'd0, pkt_valid_o}, 32'd1);
        rst_i = 1'b1;
        #1;
        check("rsthold.valid_async", {31'd0, pkt_valid_o}, 32'd0);
        check("rsthold.map_async",   {1'b0, pkt_map_o}, 32'd0);
        check("rsthold.len_async",   {27'd0, pkt_map_len_o}, 32'd1);
        tick();
        rst_i = 1'b0;
        pkt_ready_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rsthold.no_pkt", {31'd0, pkt_valid_o}, 32'd0);
        end

        // First-cycle acceptance right after reset release.
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        drive(1'b1, 1'b0, 1'b0, 5'd31, 31'h1234567, 1'b1);
        #1 check("postrst.flush", {31'd0, flush_o}, 32'd1);
        tick();
        drive(1'b0, 1'b0, 1'b1, 5'd0, 31'd0, 1'b1);
        check_pkt("postrst", 5'd0, 31'h1234567, 5'd31, 1'b0);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
